nibble_alu_sequencer: RTL and testbench
=======================================

Name: nibble_alu_sequencer

Overview:
- Initiator side of the 4-bit functional-unit en/ready handshake: drives a 4-bit carry-lookahead adder unit through two nibble operations to produce an 8-bit add or subtract.
- Sits between the CPU control FSM (start/done) and the 4-bit adder unit.
- Supplies operands, c_in and en; waits for ready; captures Output/c_out; chains the carry from the low nibble into the high nibble.
- Also provides Z/C/V flags and a timeout guard.

Parameters:
TIMEOUT, 16, max cycles fu_en may stay high without fu_ready before the operation is aborted
CNT_W, 5, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op_sub  input  1  0 = A+B, 1 = A-B; captured with start
a  input  8  operand A; captured with start
b  input  8  operand B; captured with start
busy  output  1  high from the cycle after accepted start through the DONE cycle
done  output  1  one-cycle pulse, result/flags valid
result  output  8  sum/difference; held until next accepted start
flag_c  output  1  carry out of bit 7 (for subtract: 1 = no borrow)
flag_z  output  1  result == 0
flag_v  output  1  signed overflow
error  output  1  high with done when a timeout aborted the operation
fu_en  output  1  enable to adder unit (registered)
fu_a  output  4  adder operand A nibble (registered)
fu_b  output  4  adder operand B nibble (registered, inverted when op_sub)
fu_c_in  output  1  adder carry-in (registered)
fu_sum  input  4  adder Output
fu_c_out  input  1  adder c_out (combinational in the unit from fu_a/fu_b/fu_c_in)
fu_ready  input  1  adder ready

Behaviour:
- Decided: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: all outputs 0. State is IDLE. Timeout counter is 0.
- States: IDLE, LO_REQ, GAP, HI_REQ, DONE.
- IDLE:
  - On start=1, capture a, b, op_sub.
  - Set fu_a=a[3:0], fu_b=b[3:0]^{4{op_sub}}, fu_c_in=op_sub, fu_en=1.
  - Move to LO_REQ and set busy=1.
- LO_REQ: fu_a/fu_b/fu_c_in are held stable while fu_en=1, because fu_c_out is combinational.
  - When fu_ready=1 is sampled, capture fu_sum into result[3:0] and fu_c_out into an internal carry.
  - Drop fu_en to 0 and move to GAP.
- GAP: exactly one cycle with fu_en=0. This is mandatory so the unit clears its internal count.
  - Load fu_a=a[7:4], fu_b=b[7:4]^{4{op_sub}}, fu_c_in=captured carry, fu_en=1.
  - Move to HI_REQ.
- HI_REQ: on fu_ready=1, capture result[7:4] and flag_c=fu_c_out.
  - flag_v = (a[7]==b'[7]) && (sum[7]!=a[7]), where b' is the inverted B when op_sub.
  - flag_z is computed from the full 8-bit result.
  - Drop fu_en and move to DONE.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE with busy=0. Result and flags hold until the next accepted start.
- Latency: if the unit asserts ready L cycles after the edge that raised fu_en, done is high 2L+3 cycles after the start edge. For L=3, done is high 9 cycles after start.
- fu_ready seen outside LO_REQ/HI_REQ, or while fu_en=0, is ignored.
- start while busy is ignored; no queuing.
- Timeout:
  - The counter increments each cycle in LO_REQ/HI_REQ and clears on entry to each REQ state.
  - On reaching TIMEOUT without ready: fu_en=0, result=0, flags=0, error=1, go to DONE (done pulses).
  - error is cleared on the next accepted start.
- Reset mid-operation: fu_en is 0 on the following edge, state returns to IDLE, no done pulse is issued, and result and flags clear.
- Simultaneous fu_ready and counter==TIMEOUT: ready wins and the capture proceeds normally.

Decomposition:
- Shared package alu_pkg holds:
  - State encoding localparams (IDLE=0, LO_REQ=1, GAP=2, HI_REQ=3, DONE=4).
  - OP_ADD/OP_SUB constants.
  - NIBBLE_W=4 and WORD_W=8.
- Natural sub-module: alu_flag_gen. It is combinational and computes Z/V from the result and operand MSBs. Everything else stays in one FSM module.

Test Plan:
1. Add: a=0x3C, b=0x05, op_sub=0, behavioural unit with L=3 -> done at cycle 9 after start; result=0x41, C=0, Z=0, V=0, error=0.
2. Subtract wrap: a=0x00, b=0x01, op_sub=1 -> result=0xFF, C=0 (borrow), Z=0, V=0; fu_c_in=1 on low nibble; fu_b=0xE, then fu_b=0xF.
3. Signed overflow and zero: a=0x7F, b=0x01 add -> result=0x80, V=1. a=0xFF, b=0x01 add -> result=0x00, C=1, Z=1.
4. Handshake: check fu_en is low for exactly one cycle between nibbles. Check fu_a/fu_b/fu_c_in are stable for all cycles fu_en=1. Assert start during busy -> ignored, result unchanged.
5. Timeout: unit never asserts ready, TIMEOUT=16 -> done and error at cycle 17 after fu_en rises, result=0, fu_en=0.
6. Reset in HI_REQ: assert reset for 1 cycle -> next edge fu_en=0, busy=0, result=0, no done. A following start completes normally with the correct result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, opcode values and FSM state encoding for the nibble ALU sequencer.
package alu_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LO_REQ = 3'd1,
        GAP    = 3'd2,
        HI_REQ = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/nibble_alu_sequencer_if.sv
// En/ready handshake bus between the sequencer (master) and the 4-bit adder unit (slave).
interface nibble_alu_sequencer_if;
    import alu_pkg::*;

    logic                fu_en;
    logic [NIBBLE_W-1:0] fu_a;
    logic [NIBBLE_W-1:0] fu_b;
    logic                fu_c_in;
    logic [NIBBLE_W-1:0] fu_sum;
    logic                fu_c_out;
    logic                fu_ready;

    modport master (
        output fu_en, fu_a, fu_b, fu_c_in,
        input  fu_sum, fu_c_out, fu_ready
    );

    modport slave (
        input  fu_en, fu_a, fu_b, fu_c_in,
        output fu_sum, fu_c_out, fu_ready
    );

endinterface

// File: rtl/alu_flag_gen.sv
// Zero and signed-overflow flags for the assembled 8-bit result.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [WORD_W-1:0] result,
    input  logic              a_msb,
    input  logic              b_msb,   // already inverted for subtract
    output logic              flag_z,
    output logic              flag_v
);

    assign flag_z = (result == '0);
    assign flag_v = (a_msb == b_msb) && (result[WORD_W-1] != a_msb);

endmodule

// File: rtl/nibble_alu_sequencer.sv
// Runs an 8-bit add/subtract as two chained nibble operations on a 4-bit adder unit,
// with Z/C/V flags and a timeout guard on the unit's ready.
module nibble_alu_sequencer
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_sub,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_v,
    output logic              error,
    nibble_alu_sequencer_if.master fu
);

    state_t              state_q, state_nxt;
    logic [NIBBLE_W-1:0] a_hi_q, a_hi_nxt;
    logic [NIBBLE_W-1:0] b_hi_q, b_hi_nxt;
    logic                op_q, op_nxt;
    logic                carry_q, carry_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic                en_q, en_nxt;
    logic [NIBBLE_W-1:0] fu_a_q, fu_a_nxt;
    logic [NIBBLE_W-1:0] fu_b_q, fu_b_nxt;
    logic                c_in_q, c_in_nxt;
    logic [WORD_W-1:0]   result_q, result_nxt;
    logic                flag_c_q, flag_c_nxt;
    logic                flag_z_q, flag_z_nxt;
    logic                flag_v_q, flag_v_nxt;
    logic                error_q, error_nxt;

    logic [WORD_W-1:0]   hi_result;
    logic                gen_z, gen_v;
    logic                timed_out;
    logic                ready_seen;

    assign hi_result  = {fu.fu_sum, result_q[NIBBLE_W-1:0]};
    assign timed_out  = (cnt_q == CNT_W'(TIMEOUT));
    assign ready_seen = fu.fu_ready && en_q;

    // In HI_REQ fu_b_q holds b'[7:4], so its MSB is the effective B sign bit.
    alu_flag_gen u_flag_gen (
        .result (hi_result),
        .a_msb  (a_hi_q[NIBBLE_W-1]),
        .b_msb  (fu_b_q[NIBBLE_W-1]),
        .flag_z (gen_z),
        .flag_v (gen_v)
    );

    always_comb begin
        // NOTE: every *_nxt gets its hold value first so no path through the case infers a latch.
        state_nxt  = state_q;
        a_hi_nxt   = a_hi_q;
        b_hi_nxt   = b_hi_q;
        op_nxt     = op_q;
        carry_nxt  = carry_q;
        cnt_nxt    = cnt_q;
        en_nxt     = en_q;
        fu_a_nxt   = fu_a_q;
        fu_b_nxt   = fu_b_q;
        c_in_nxt   = c_in_q;
        result_nxt = result_q;
        flag_c_nxt = flag_c_q;
        flag_z_nxt = flag_z_q;
        flag_v_nxt = flag_v_q;
        error_nxt  = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_hi_nxt   = a[WORD_W-1:NIBBLE_W];
                    b_hi_nxt   = b[WORD_W-1:NIBBLE_W];
                    op_nxt     = op_sub;
                    fu_a_nxt   = a[NIBBLE_W-1:0];
                    fu_b_nxt   = b[NIBBLE_W-1:0] ^ {NIBBLE_W{op_sub == OP_SUB}};
                    c_in_nxt   = (op_sub == OP_SUB);
                    en_nxt     = 1'b1;
                    cnt_nxt    = '0;
                    result_nxt = '0;
                    flag_c_nxt = 1'b0;
                    flag_z_nxt = 1'b0;
                    flag_v_nxt = 1'b0;
                    error_nxt  = 1'b0;
                    state_nxt  = LO_REQ;
                end
            end

            LO_REQ, HI_REQ: begin
                // Ready is checked before the timeout so a last-cycle ready still completes.
                if (ready_seen) begin
                    en_nxt = 1'b0;
                    if (state_q == LO_REQ) begin
                        result_nxt[NIBBLE_W-1:0] = fu.fu_sum;
                        carry_nxt                = fu.fu_c_out;
                        state_nxt                = GAP;
                    end else begin
                        result_nxt = hi_result;
                        flag_c_nxt = fu.fu_c_out;
                        flag_z_nxt = gen_z;
                        flag_v_nxt = gen_v;
                        state_nxt  = DONE;
                    end
                end else if (timed_out) begin
                    en_nxt     = 1'b0;
                    result_nxt = '0;
                    flag_c_nxt = 1'b0;
                    flag_z_nxt = 1'b0;
                    flag_v_nxt = 1'b0;
                    error_nxt  = 1'b1;
                    state_nxt  = DONE;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            GAP: begin
                // The unit sees fu_en low for this one cycle and resets its internal count.
                fu_a_nxt  = a_hi_q;
                fu_b_nxt  = b_hi_q ^ {NIBBLE_W{op_q == OP_SUB}};
                c_in_nxt  = carry_q;
                en_nxt    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = HI_REQ;
            end

            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update ordered against this edge.
        if (reset) begin
            state_q  <= IDLE;
            a_hi_q   <= '0;
            b_hi_q   <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            fu_a_q   <= '0;
            fu_b_q   <= '0;
            c_in_q   <= 1'b0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_v_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            a_hi_q   <= a_hi_nxt;
            b_hi_q   <= b_hi_nxt;
            op_q     <= op_nxt;
            carry_q  <= carry_nxt;
            cnt_q    <= cnt_nxt;
            en_q     <= en_nxt;
            fu_a_q   <= fu_a_nxt;
            fu_b_q   <= fu_b_nxt;
            c_in_q   <= c_in_nxt;
            result_q <= result_nxt;
            flag_c_q <= flag_c_nxt;
            flag_z_q <= flag_z_nxt;
            flag_v_q <= flag_v_nxt;
            error_q  <= error_nxt;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign result     = result_q;
    assign flag_c     = flag_c_q;
    assign flag_z     = flag_z_q;
    assign flag_v     = flag_v_q;
    assign error      = error_q;
    assign fu.fu_en   = en_q;
    assign fu.fu_a    = fu_a_q;
    assign fu.fu_b    = fu_b_q;
    assign fu.fu_c_in = c_in_q;

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Directed bench for nibble_alu_sequencer with a behavioural 4-bit adder unit of programmable latency.
module tb_nibble_alu_sequencer;
    import alu_pkg::*;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       op_sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       flag_c;
    logic       flag_z;
    logic       flag_v;
    logic       error;

    nibble_alu_sequencer_if fu_bus ();

    nibble_alu_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .flag_v (flag_v),
        .error  (error),
        .fu     (fu_bus)
    );

    always #5 clk = ~clk;

    // Adder unit: ready rises L edges after it first sees fu_en high; L=0 means never ready.
    int   unit_l = 3;
    int   ucnt   = 0;
    logic urdy   = 1'b0;

    always @(posedge clk) begin
        if (!fu_bus.fu_en) begin
            ucnt <= 0;
            urdy <= 1'b0;
        end else begin
            ucnt <= ucnt + 1;
            urdy <= (unit_l != 0) && (ucnt + 1 >= unit_l);
        end
    end

    assign fu_bus.fu_ready = urdy;
    assign {fu_bus.fu_c_out, fu_bus.fu_sum} = {1'b0, fu_bus.fu_a} + {1'b0, fu_bus.fu_b}
                                              + {4'b0, fu_bus.fu_c_in};

    // Operand stability while fu_en stays high.
    int       stab_err = 0;
    logic     mon_en   = 1'b0;
    logic [8:0] mon_ops = '0;

    always @(negedge clk) begin
        if (fu_bus.fu_en && mon_en && ({fu_bus.fu_a, fu_bus.fu_b, fu_bus.fu_c_in} != mon_ops))
            stab_err <= stab_err + 1;
        mon_en  <= fu_bus.fu_en;
        mon_ops <= {fu_bus.fu_a, fu_bus.fu_b, fu_bus.fu_c_in};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int         lat;
    int         gap_len;
    int         rises;
    logic [3:0] b_lo, b_hi;
    logic       cin_lo, cin_hi;

    // Issues one operation and waits (bounded) for done; lat counts edges from the start edge.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic top, input bit poke);
        int   n;
        logic prev_en;
        @(negedge clk);
        start = 1'b1; a = ta; b = tbv; op_sub = top;
        @(negedge clk);
        start = 1'b0; a = 8'hA5; b = 8'h5A; op_sub = ~top;
        n = 0; prev_en = 1'b0; rises = 0; gap_len = 0;
        b_lo = 'x; b_hi = 'x; cin_lo = 1'bx; cin_hi = 1'bx;
        while (!done && n < 100) begin
            if (fu_bus.fu_en && !prev_en) begin
                rises++;
                if (rises == 1) begin b_lo = fu_bus.fu_b; cin_lo = fu_bus.fu_c_in; end
                else            begin b_hi = fu_bus.fu_b; cin_hi = fu_bus.fu_c_in; end
            end
            if (!fu_bus.fu_en && rises == 1) gap_len++;
            prev_en = fu_bus.fu_en;
            if (poke && n == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
            if (poke && n == 3) start = 1'b0;
            @(negedge clk);
            n++;
        end
        lat = n;
    endtask

    int done_seen;

    initial begin
        reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy), 32'd0);
        check("reset_done",   32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_fu_en",  32'(fu_bus.fu_en), 32'd0);
        check("reset_err_fl", 32'({error, flag_c, flag_z, flag_v}), 32'd0);
        reset = 1'b0;

        // 0x3C + 0x05, L=3
        do_op(8'h3C, 8'h05, OP_ADD, 1'b0);
        check("add_latency", 32'(lat), 32'd9);
        check("add_result",  32'(result), 32'h41);
        check("add_czv",     32'({flag_c, flag_z, flag_v}), 32'b000);
        check("add_error",   32'(error), 32'd0);
        check("add_busy_done", 32'(busy), 32'd1);
        check("add_gap",     32'(gap_len), 32'd1);
        @(negedge clk);
        check("add_idle_busy", 32'(busy), 32'd0);
        check("add_idle_done", 32'(done), 32'd0);

        // 0x00 - 0x01 wraps with borrow
        do_op(8'h00, 8'h01, OP_SUB, 1'b0);
        check("sub_result", 32'(result), 32'hFF);
        check("sub_czv",    32'({flag_c, flag_z, flag_v}), 32'b000);
        check("sub_b_lo",   32'(b_lo), 32'hE);
        check("sub_cin_lo", 32'(cin_lo), 32'd1);
        check("sub_b_hi",   32'(b_hi), 32'hF);
        check("sub_cin_hi", 32'(cin_hi), 32'd0);
        check("sub_gap",    32'(gap_len), 32'd1);

        // Signed overflow with a fast unit, L=1 -> 2L+3 = 5
        unit_l = 1;
        do_op(8'h7F, 8'h01, OP_ADD, 1'b0);
        check("ovf_latency", 32'(lat), 32'd5);
        check("ovf_result",  32'(result), 32'h80);
        check("ovf_czv",     32'({flag_c, flag_z, flag_v}), 32'b001);
        unit_l = 3;

        do_op(8'hFF, 8'h01, OP_ADD, 1'b0);
        check("zero_result", 32'(result), 32'h00);
        check("zero_czv",    32'({flag_c, flag_z, flag_v}), 32'b110);

        do_op(8'h80, 8'h01, OP_SUB, 1'b0);
        check("subovf_result", 32'(result), 32'h7F);
        check("subovf_czv",    32'({flag_c, flag_z, flag_v}), 32'b101);

        do_op(8'h50, 8'h30, OP_SUB, 1'b0);
        check("sub2_result", 32'(result), 32'h20);
        check("sub2_czv",    32'({flag_c, flag_z, flag_v}), 32'b100);

        // Start while busy must be ignored and not queued
        do_op(8'h12, 8'h34, OP_ADD, 1'b1);
        check("poke_result",  32'(result), 32'h46);
        check("poke_latency", 32'(lat), 32'd9);
        @(negedge clk);
        @(negedge clk);
        check("poke_no_queue_busy", 32'(busy), 32'd0);
        check("poke_no_queue_en",   32'(fu_bus.fu_en), 32'd0);
        check("operand_stability",  32'(stab_err), 32'd0);

        // Unit never ready -> abort after TIMEOUT+1 edges
        unit_l = 0;
        do_op(8'h55, 8'h11, OP_ADD, 1'b0);
        check("to_latency", 32'(lat), 32'(TIMEOUT + 1));
        check("to_error",   32'(error), 32'd1);
        check("to_result",  32'(result), 32'd0);
        check("to_flags",   32'({flag_c, flag_z, flag_v}), 32'd0);
        check("to_fu_en",   32'(fu_bus.fu_en), 32'd0);
        @(negedge clk);
        check("to_error_held", 32'(error), 32'd1);
        unit_l = 3;

        // Reset during HI_REQ
        @(negedge clk);
        start = 1'b1; a = 8'h2A; b = 8'h03; op_sub = OP_ADD;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_in_hi_en", 32'(fu_bus.fu_en), 32'd1);
        check("rst_in_hi_err_cleared", 32'(error), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_fu_en",  32'(fu_bus.fu_en), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("rst_no_done", 32'(done_seen), 32'd0);

        do_op(8'h2A, 8'h03, OP_ADD, 1'b0);
        check("post_rst_latency", 32'(lat), 32'd9);
        check("post_rst_result",  32'(result), 32'h2D);
        check("post_rst_error",   32'(error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
